// File: rtl/if_stage_pkg.sv
// Shared types for the fetch stage: fetch-address source select and stage state.
package if_stage_pkg;

    localparam int unsigned FETCH_SEL_NUM_INPUTS = 5;

    typedef enum logic [$clog2(FETCH_SEL_NUM_INPUTS)-1:0] {
        FETCH_SEL_RESET,
        FETCH_SEL_FLUSH,
        FETCH_SEL_HOLD,
        FETCH_SEL_TARGET,
        FETCH_SEL_SEQ
    } fetch_sel_e;

    typedef enum logic {
        IF_STATE_BOOT,
        IF_STATE_RUN
    } if_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_perf_counters.sv
// Fetch-stage performance counters; only compiled when IF_PERF_CNT_EN is defined.
`ifdef IF_PERF_CNT_EN
module if_perf_counters (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_inc_i,
    input  logic        redirect_inc_i,
    input  logic        stall_inc_i,
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] redirect_cnt_o,
    output logic [31:0] stall_cnt_o
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_cnt_o    <= '0;
            redirect_cnt_o <= '0;
            stall_cnt_o    <= '0;
        end else begin
            fetch_cnt_o    <= fetch_cnt_o    + 32'(fetch_inc_i);
            redirect_cnt_o <= redirect_cnt_o + 32'(redirect_inc_i);
            stall_cnt_o    <= stall_cnt_o    + 32'(stall_inc_i);
        end
    end

endmodule
`endif

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, drives BIOS/IMEM read ports and the ID-stage PC.
// Optional performance counters are added when IF_PERF_CNT_EN is defined.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h4000_0000,
    parameter int unsigned BIOS_AW  = 12,
    parameter int unsigned IMEM_AW  = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_flush,
    input  logic [31:0]        ex_pc_target,
    input  logic [31:0]        if_pc_target,
    input  logic               if_target_taken,
    input  logic               id_stall,
    output logic [BIOS_AW-1:0] bios_addr,
    output logic               bios_en,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic               imem_en,
    output logic [31:0]        id_pc,
    output logic               id_valid,
    output logic               if_misalign
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetch,
    output logic [31:0]        perf_redirect,
    output logic [31:0]        perf_stall
`endif
);

    if_state_e   state_q;
    logic [31:0] id_pc_q;
    logic        misalign_q;
    logic        misalign_d;
    fetch_sel_e  sel;
    logic [31:0] fetch_pc;

    // Redirects and stalls only matter once the stage is running out of reset.
    always_comb begin
        sel = FETCH_SEL_SEQ;
        if (!rst || state_q == IF_STATE_BOOT) sel = FETCH_SEL_RESET;
        else if (ex_flush)                    sel = FETCH_SEL_FLUSH;
        else if (id_stall)                    sel = FETCH_SEL_HOLD;
        else if (if_target_taken)             sel = FETCH_SEL_TARGET;
    end

    always_comb begin
        fetch_pc = id_pc_q + 32'd4;
        case (sel)
            FETCH_SEL_RESET:  fetch_pc = RESET_PC;
            FETCH_SEL_FLUSH:  fetch_pc = word_align(ex_pc_target);
            FETCH_SEL_HOLD:   fetch_pc = id_pc_q;
            FETCH_SEL_TARGET: fetch_pc = word_align(if_pc_target);
            default:          fetch_pc = id_pc_q + 32'd4;
        endcase
    end

    always_comb begin
        misalign_d = misalign_q;
        if (sel == FETCH_SEL_FLUSH && ex_pc_target[1:0] != 2'b00)  misalign_d = 1'b1;
        if (sel == FETCH_SEL_TARGET && if_pc_target[1:0] != 2'b00) misalign_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IF_STATE_BOOT;
            id_pc_q    <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= IF_STATE_RUN;
            id_pc_q    <= fetch_pc;
            misalign_q <= misalign_d;
        end
    end

    assign bios_addr   = fetch_pc[BIOS_AW+1:2];
    assign bios_en     = fetch_pc[30];
    assign imem_addr   = fetch_pc[IMEM_AW+1:2];
    assign imem_en     = ~fetch_pc[30];
    assign id_pc       = id_pc_q;
    assign id_valid    = (state_q == IF_STATE_RUN);
    assign if_misalign = misalign_q;

`ifdef IF_PERF_CNT_EN
    logic running;
    assign running = rst && (state_q == IF_STATE_RUN);

    if_perf_counters u_perf (
        .clk            (clk),
        .rst            (rst),
        .fetch_inc_i    (running && !id_stall && !ex_flush),
        .redirect_inc_i (sel == FETCH_SEL_FLUSH || sel == FETCH_SEL_TARGET),
        .stall_inc_i    (running && id_stall && !ex_flush),
        .fetch_cnt_o    (perf_fetch),
        .redirect_cnt_o (perf_redirect),
        .stall_cnt_o    (perf_stall)
    );
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by random traffic
// against a behavioural fetch model.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst, ex_flush, if_target_taken, id_stall;
    logic [31:0] ex_pc_target, if_pc_target;
    logic [11:0] bios_addr;
    logic        bios_en;
    logic [13:0] imem_addr;
    logic        imem_en;
    logic [31:0] id_pc;
    logic        id_valid, if_misalign;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch, perf_redirect, perf_stall;
`endif

    int checks = 0;
    int errors = 0;

    // Model state
    logic [31:0] m_pc = RESET_PC;
    logic        m_run = 1'b0;
    logic        m_mis = 1'b0;
`ifdef IF_PERF_CNT_EN
    logic [31:0] m_pf = '0, m_pr = '0, m_ps = '0;
`endif

    if_stage #(
        .RESET_PC (RESET_PC),
        .BIOS_AW  (12),
        .IMEM_AW  (14)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ex_flush        (ex_flush),
        .ex_pc_target    (ex_pc_target),
        .if_pc_target    (if_pc_target),
        .if_target_taken (if_target_taken),
        .id_stall        (id_stall),
        .bios_addr       (bios_addr),
        .bios_en         (bios_en),
        .imem_addr       (imem_addr),
        .imem_en         (imem_en),
        .id_pc           (id_pc),
        .id_valid        (id_valid),
        .if_misalign     (if_misalign)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch      (perf_fetch),
        .perf_redirect   (perf_redirect),
        .perf_stall      (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Next fetch address from the current model state and inputs.
    function automatic logic [31:0] model_fetch();
        if (!rst || !m_run)    return RESET_PC;
        if (ex_flush)          return {ex_pc_target[31:2], 2'b00};
        if (id_stall)          return m_pc;
        if (if_target_taken)   return {if_pc_target[31:2], 2'b00};
        return m_pc + 32'd4;
    endfunction

    task automatic set_in(input logic r, input logic f, input logic [31:0] et,
                          input logic tk, input logic [31:0] it, input logic st);
        rst = r; ex_flush = f; ex_pc_target = et;
        if_target_taken = tk; if_pc_target = it; id_stall = st;
        #2;
    endtask

    task automatic check_all();
        logic [31:0] fa;
        fa = model_fetch();
        chk("id_pc",       id_pc,                m_pc);
        chk("id_valid",    32'(id_valid),        32'(m_run));
        chk("if_misalign", 32'(if_misalign),     32'(m_mis));
        chk("bios_en",     32'(bios_en),         32'(fa[30]));
        chk("imem_en",     32'(imem_en),         32'(!fa[30]));
        chk("bios_addr",   32'(bios_addr),       32'(fa[13:2]));
        chk("imem_addr",   32'(imem_addr),       32'(fa[15:2]));
`ifdef IF_PERF_CNT_EN
        chk("perf_fetch",    perf_fetch,    m_pf);
        chk("perf_redirect", perf_redirect, m_pr);
        chk("perf_stall",    perf_stall,    m_ps);
`endif
    endtask

    task automatic model_clock();
        logic [31:0] fa;
        fa = model_fetch();
        if (!rst) begin
            m_pc = RESET_PC; m_run = 1'b0; m_mis = 1'b0;
`ifdef IF_PERF_CNT_EN
            m_pf = '0; m_pr = '0; m_ps = '0;
`endif
        end else begin
            if (m_run && ex_flush && ex_pc_target[1:0] != 2'b00) m_mis = 1'b1;
            if (m_run && !ex_flush && !id_stall && if_target_taken && if_pc_target[1:0] != 2'b00)
                m_mis = 1'b1;
`ifdef IF_PERF_CNT_EN
            if (m_run && !id_stall && !ex_flush) m_pf = m_pf + 1;
            if (m_run && (ex_flush || (!id_stall && if_target_taken))) m_pr = m_pr + 1;
            if (m_run && id_stall && !ex_flush) m_ps = m_ps + 1;
`endif
            m_pc  = fa;
            m_run = 1'b1;
        end
    endtask

    task automatic step(input logic r, input logic f, input logic [31:0] et,
                        input logic tk, input logic [31:0] it, input logic st);
        set_in(r, f, et, tk, it, st);
        check_all();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_in(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        @(posedge clk); #1;

        // Reset state
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        chk("rst_id_pc", id_pc, 32'h4000_0000);
        chk("rst_valid", 32'(id_valid), 32'd0);
        chk("rst_misalign", 32'(if_misalign), 32'd0);

        // Boot sequence
        set_in(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        chk("boot_bios_addr0", 32'(bios_addr), 32'd0);
        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        chk("boot_pc0", id_pc, 32'h4000_0000);
        chk("boot_valid", 32'(id_valid), 32'd1);
        set_in(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        chk("boot_bios_addr1", 32'(bios_addr), 32'd1);
        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        chk("boot_pc1", id_pc, 32'h4000_0004);
        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        chk("boot_pc2", id_pc, 32'h4000_0008);

        // ID redirect into IMEM, no bubble
        set_in(1'b1, 1'b0, '0, 1'b1, 32'h0000_0100, 1'b0);
        chk("tgt_imem_en", 32'(imem_en), 32'd1);
        chk("tgt_imem_addr", 32'(imem_addr), 32'h40);
        step(1'b1, 1'b0, '0, 1'b1, 32'h0000_0100, 1'b0);
        chk("tgt_pc", id_pc, 32'h0000_0100);
        chk("tgt_valid", 32'(id_valid), 32'd1);

        // Stall for three cycles at 0x10
        step(1'b1, 1'b1, 32'h0000_0010, 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, '0, 1'b1, 32'h0000_0800, 1'b1);
            chk("stall_pc", id_pc, 32'h0000_0010);
        end
        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        chk("stall_resume", id_pc, 32'h0000_0014);

        // Flush beats stall and target together
        step(1'b1, 1'b1, 32'h0000_0200, 1'b1, 32'h0000_0300, 1'b1);
        chk("flush_prio", id_pc, 32'h0000_0200);
        chk("flush_no_mis", 32'(if_misalign), 32'd0);

        // Misaligned flush target is aligned and latches the sticky flag
        step(1'b1, 1'b1, 32'h0000_0202, 1'b0, '0, 1'b0);
        chk("mis_pc", id_pc, 32'h0000_0200);
        chk("mis_set", 32'(if_misalign), 32'd1);
        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        step(1'b1, 1'b1, 32'h0000_0040, 1'b0, '0, 1'b0);
        chk("mis_sticky", 32'(if_misalign), 32'd1);
        chk("pre_rst_pc", id_pc, 32'h0000_0040);

        // One-cycle reset mid-stream
        step(1'b0, 1'b1, 32'h0000_0500, 1'b1, 32'h0000_0600, 1'b0);
        chk("midrst_pc", id_pc, 32'h4000_0000);
        chk("midrst_valid", 32'(id_valid), 32'd0);
        chk("midrst_mis", 32'(if_misalign), 32'd0);
        step(1'b1, 1'b1, 32'h0000_0500, 1'b1, 32'h0000_0600, 1'b1);
        chk("reboot_pc0", id_pc, 32'h4000_0000);
        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
        chk("reboot_pc1", id_pc, 32'h4000_0004);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] et, it;
            et = $urandom;
            it = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                et[1:0] = 2'b00;
                it[1:0] = 2'b00;
            end
            step(($urandom_range(0, 31) != 0), ($urandom_range(0, 7) == 0), et,
                 ($urandom_range(0, 3) == 0), it, ($urandom_range(0, 3) == 0));
        end
        check_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
